// File: rtl/sdr_data_path_pipe_if.sv
// SDRAM data-path bus bundle: host write/read beats, pin-side DQ/DQM, read return.
// No storage; carries signals only.
// No backpressure: every beat presented is taken in the cycle it is presented.
interface sdr_data_path_pipe_if #(
    parameter int DSIZE = 16
) ();
    logic [DSIZE-1:0]   DATAIN;
    logic [DSIZE/8-1:0] DM;
    logic               WR_EN;
    logic               RD_EN;
    logic [DSIZE-1:0]   DQIN;
    logic [DSIZE-1:0]   DQOUT;
    logic               DQ_OE;
    logic [DSIZE/8-1:0] DQM;
    logic [DSIZE-1:0]   RDATA;
    logic               RVALID;
    logic               ERR;

    // Controller side: issues beats, supplies sampled DQ, receives read data.
    modport master (
        output DATAIN, DM, WR_EN, RD_EN, DQIN,
        input  DQOUT, DQ_OE, DQM, RDATA, RVALID, ERR
    );

    // Data-path side.
    modport slave (
        input  DATAIN, DM, WR_EN, RD_EN, DQIN,
        output DQOUT, DQ_OE, DQM, RDATA, RVALID, ERR
    );
endinterface

// File: rtl/sdr_data_path_pipe.sv
// SDRAM data-path stage: write data/DQ_OE/DQM to the pins, CAS-aligned read capture, sticky conflict flag.
// Latency: write 1 clk (OUT_REG=1) or 0 clk (OUT_REG=0); DQM 1 clk; read data valid CAS_LAT+1 clks after RD_EN.
// No backpressure: one beat per clock in either direction; a read colliding with a write is dropped and flagged.
module sdr_data_path_pipe #(
    parameter int DSIZE   = 16,
    parameter int CAS_LAT = 2,
    parameter int OUT_REG = 1
) (
    input logic                 CLK,
    input logic                 RESET_N,
    sdr_data_path_pipe_if.slave bus
);
    localparam int MSIZE = DSIZE / 8;

    // Reject configurations the pipeline cannot represent.
    generate
        if (CAS_LAT < 1 || CAS_LAT > 3) begin : g_bad_cas_lat
            $error("sdr_data_path_pipe: CAS_LAT must be 1..3");
        end
        if (DSIZE < 8 || (DSIZE % 8) != 0) begin : g_bad_dsize
            $error("sdr_data_path_pipe: DSIZE must be a non-zero multiple of 8");
        end
    endgenerate

    logic [CAS_LAT:0] rd_pipe;
    logic [DSIZE-1:0] rdata_q;
    logic [MSIZE-1:0] dqm_q;
    logic             err_q;
    logic             rd_accept;
    logic             wr_conflict;

    // A write always wins the bus; a read in the same cycle never enters the pipe.
    assign rd_accept   = bus.RD_EN & ~bus.WR_EN;
    // Bits below CAS_LAT mark reads whose data is still due on DQ (this cycle or later).
    assign wr_conflict = bus.WR_EN & (bus.RD_EN | (|rd_pipe[CAS_LAT-1:0]));

    // Read tracking shift register; reset discards in-flight reads.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[CAS_LAT-1:0], rd_accept};
        end
    end

    // Capture DQ at the end of the cycle the SDRAM drives it; hold otherwise.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rdata_q <= '0;
        end else if (rd_pipe[CAS_LAT-1]) begin
            rdata_q <= bus.DQIN;
        end
    end

    // Byte mask follows DM on active beats, masks everything when idle.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dqm_q <= '1;
        end else if (bus.WR_EN || bus.RD_EN) begin
            dqm_q <= bus.DM;
        end else begin
            dqm_q <= '1;
        end
    end

    // Sticky bus-turnaround conflict flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            err_q <= 1'b0;
        end else if (wr_conflict) begin
            err_q <= 1'b1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DSIZE-1:0] dqout_q;
            logic             dq_oe_q;

            // Registered write path: data held between writes, drive only on write beats.
            always_ff @(posedge CLK) begin
                if (!RESET_N) begin
                    dqout_q <= '0;
                    dq_oe_q <= 1'b0;
                end else begin
                    dq_oe_q <= bus.WR_EN;
                    if (bus.WR_EN) begin
                        dqout_q <= bus.DATAIN;
                    end
                end
            end

            assign bus.DQOUT = dqout_q;
            assign bus.DQ_OE = dq_oe_q;
        end else begin : g_out_comb
            assign bus.DQOUT = bus.DATAIN;
            assign bus.DQ_OE = bus.WR_EN & RESET_N;
        end
    endgenerate

    assign bus.DQM    = dqm_q;
    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rd_pipe[CAS_LAT];
    assign bus.ERR    = err_q;

endmodule

// File: tb/tb_sdr_data_path_pipe.sv
module tb_sdr_data_path_pipe;
    logic CLK = 1'b0;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    // a: 16-bit, CL2, registered. b: 16-bit, CL3, combinational. c: 32-bit, CL2, registered.
    sdr_data_path_pipe_if #(.DSIZE(16)) a_if ();
    sdr_data_path_pipe_if #(.DSIZE(16)) b_if ();
    sdr_data_path_pipe_if #(.DSIZE(32)) c_if ();

    sdr_data_path_pipe #(.DSIZE(16), .CAS_LAT(2), .OUT_REG(1)) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .bus(a_if.slave));
    sdr_data_path_pipe #(.DSIZE(16), .CAS_LAT(3), .OUT_REG(0)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .bus(b_if.slave));
    sdr_data_path_pipe #(.DSIZE(32), .CAS_LAT(2), .OUT_REG(1)) dut_c (
        .CLK(CLK), .RESET_N(RESET_N), .bus(c_if.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0;
        a_if.DATAIN = 16'h1234; a_if.DM = 2'b00; a_if.WR_EN = 1'b1; a_if.RD_EN = 1'b0; a_if.DQIN = '0;
        b_if.DATAIN = 16'h1234; b_if.DM = 2'b00; b_if.WR_EN = 1'b1; b_if.RD_EN = 1'b0; b_if.DQIN = '0;
        c_if.DATAIN = 32'h1234; c_if.DM = 4'h0;  c_if.WR_EN = 1'b1; c_if.RD_EN = 1'b0; c_if.DQIN = '0;

        // Reset held 3 clocks with WR_EN asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_a_dqm",    a_if.DQM,    2'b11);
            chk("rst_a_dq_oe",  a_if.DQ_OE,  1'b0);
            chk("rst_a_dqout",  a_if.DQOUT,  16'h0000);
            chk("rst_a_rvalid", a_if.RVALID, 1'b0);
            chk("rst_a_err",    a_if.ERR,    1'b0);
            chk("rst_a_rdata",  a_if.RDATA,  16'h0000);
            chk("rst_b_dq_oe",  b_if.DQ_OE,  1'b0);
            chk("rst_c_dqm",    c_if.DQM,    4'hF);
        end

        // Release with everything idle.
        RESET_N = 1'b1;
        a_if.WR_EN = 1'b0; b_if.WR_EN = 1'b0; c_if.WR_EN = 1'b0;
        step();
        chk("idle_a_dq_oe", a_if.DQ_OE, 1'b0);
        chk("idle_a_dqm",   a_if.DQM,   2'b11);

        // Write latency on the registered 16-bit path.
        a_if.DATAIN = 16'hA5C3; a_if.DM = 2'b01; a_if.WR_EN = 1'b1;
        step();
        chk("wr_a_dqout", a_if.DQOUT, 16'hA5C3);
        chk("wr_a_dq_oe", a_if.DQ_OE, 1'b1);
        chk("wr_a_dqm",   a_if.DQM,   2'b01);
        a_if.DATAIN = 16'hFFFF; a_if.DM = 2'b00; a_if.WR_EN = 1'b0;
        step();
        chk("wr_a_oe_off", a_if.DQ_OE, 1'b0);
        chk("wr_a_dqm_id", a_if.DQM,   2'b11);
        chk("wr_a_hold",   a_if.DQOUT, 16'hA5C3);

        // Four back-to-back reads at CL2; DQIN = 0x1014 + relative cycle.
        a_if.DM = 2'b10;
        for (int c = 0; c < 8; c++) begin
            a_if.RD_EN = (c < 4);
            a_if.DQIN  = 16'h1014 + 16'(c);
            step();
            chk("rd_a_rvalid", a_if.RVALID, ((c + 1) >= 3 && (c + 1) <= 6));
            if ((c + 1) >= 3 && (c + 1) <= 6)
                chk("rd_a_rdata", a_if.RDATA, 16'h1014 + 16'(c));
            if (c == 0)
                chk("rd_a_dqm", a_if.DQM, 2'b10);
        end
        chk("rd_a_hold", a_if.RDATA, 16'h1019);
        chk("rd_a_noerr", a_if.ERR, 1'b0);

        // Write one cycle after a read whose data is still due.
        a_if.RD_EN = 1'b1; a_if.DQIN = 16'h0000;
        step();
        chk("cf_a_err0", a_if.ERR, 1'b0);
        a_if.RD_EN = 1'b0; a_if.WR_EN = 1'b1; a_if.DATAIN = 16'h7777;
        step();
        chk("cf_a_err1",  a_if.ERR,   1'b1);
        chk("cf_a_dq_oe", a_if.DQ_OE, 1'b1);
        chk("cf_a_dqout", a_if.DQOUT, 16'h7777);
        a_if.WR_EN = 1'b0;
        step();
        chk("cf_a_rvalid", a_if.RVALID, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cf_a_sticky", a_if.ERR, 1'b1);
        end

        // Reset clears the sticky flag.
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        chk("cf_a_cleared", a_if.ERR, 1'b0);

        // Simultaneous write and read: write executes, read dropped.
        a_if.WR_EN = 1'b1; a_if.RD_EN = 1'b1; a_if.DATAIN = 16'h5555;
        step();
        chk("sim_a_err",   a_if.ERR,   1'b1);
        chk("sim_a_dqout", a_if.DQOUT, 16'h5555);
        a_if.WR_EN = 1'b0; a_if.RD_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sim_a_norv", a_if.RVALID, 1'b0);
        end

        // Reset mid-read discards the beat.
        a_if.RD_EN = 1'b1;
        step();
        a_if.RD_EN = 1'b0; RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        chk("mrst_a_rvalid", a_if.RVALID, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_a_rvalid", a_if.RVALID, 1'b0);
            chk("mrst_a_err",    a_if.ERR,    1'b0);
        end

        // CL3 single read; DQIN=BEEF only in the data cycle.
        b_if.DM = 2'b00;
        for (int c = 0; c < 7; c++) begin
            b_if.RD_EN = (c == 0);
            b_if.DQIN  = (c == 3) ? 16'hBEEF : 16'h0000;
            step();
            chk("cl3_b_rvalid", b_if.RVALID, (c + 1) == 4);
            if ((c + 1) == 4)
                chk("cl3_b_rdata", b_if.RDATA, 16'hBEEF);
        end
        chk("cl3_b_hold", b_if.RDATA, 16'hBEEF);

        // Combinational write path: same-cycle DQOUT/DQ_OE, DQM still registered.
        b_if.WR_EN = 1'b1; b_if.DATAIN = 16'h3C3C; b_if.DM = 2'b10;
        #1;
        chk("comb_b_dqout", b_if.DQOUT, 16'h3C3C);
        chk("comb_b_dq_oe", b_if.DQ_OE, 1'b1);
        chk("comb_b_dqm_pre", b_if.DQM, 2'b11);
        step();
        chk("comb_b_dqm", b_if.DQM, 2'b10);
        b_if.WR_EN = 1'b0;
        #1;
        chk("comb_b_oe_off", b_if.DQ_OE, 1'b0);

        // 32-bit write with 4-bit mask.
        c_if.WR_EN = 1'b0;
        step();
        c_if.DATAIN = 32'hDEADBEEF; c_if.DM = 4'b0101; c_if.WR_EN = 1'b1;
        step();
        chk("wr_c_dqout", c_if.DQOUT, 32'hDEADBEEF);
        chk("wr_c_dq_oe", c_if.DQ_OE, 1'b1);
        chk("wr_c_dqm",   c_if.DQM,   4'b0101);
        c_if.WR_EN = 1'b0;
        step();
        chk("wr_c_oe_off", c_if.DQ_OE, 1'b0);
        chk("wr_c_dqm_id", c_if.DQM,   4'hF);

        // 32-bit back-to-back reads at CL2.
        for (int c = 0; c < 6; c++) begin
            c_if.RD_EN = (c < 2);
            c_if.DQIN  = 32'h2000_0000 + 32'(c);
            step();
            chk("rd_c_rvalid", c_if.RVALID, ((c + 1) == 3 || (c + 1) == 4));
            if ((c + 1) == 3 || (c + 1) == 4)
                chk("rd_c_rdata", c_if.RDATA, 32'h2000_0000 + 32'(c));
        end
        chk("rd_c_noerr", c_if.ERR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdr_data_path_pipe.md
Name: sdr_data_path_pipe

Overview:
Parametrised SDRAM data-path stage between the 4-port SDRAM controller command logic and the SDRAM DQ/DQM pins. Generalises the write-only data path. Adds:
- data width and CAS latency parameters;
- optional output registering;
- a DQ output-enable;
- a CAS-latency-aligned read capture pipeline with a valid strobe;
- sticky detection of bus-turnaround conflicts.

Parameters:
DSIZE, 16, data bus width in bits; must be a multiple of 8.
CAS_LAT, 2, SDRAM CAS latency in clocks; legal values 1..3.
OUT_REG, 1, 1 = DQOUT/DQ_OE registered (1-cycle write latency); 0 = DQOUT/DQ_OE combinational from DATAIN/WR_EN.

Ports:
CLK  in  1  controller clock; all logic on rising edge.
RESET_N  in  1  reset, synchronous, active-low.
DATAIN  in  DSIZE  host write data for the current beat.
DM  in  DSIZE/8  host byte mask; 1 = byte masked.
WR_EN  in  1  write beat issued this cycle.
RD_EN  in  1  read beat issued to the SDRAM this cycle.
DQIN  in  DSIZE  sampled SDRAM DQ input.
DQOUT  out  DSIZE  data driven to SDRAM DQ.
DQ_OE  out  1  DQ tristate enable; 1 = drive.
DQM  out  DSIZE/8  byte mask to SDRAM, always registered.
RDATA  out  DSIZE  captured read data.
RVALID  out  1  RDATA valid, one-cycle pulse per read beat.
ERR  out  1  sticky bus-conflict flag.

Behaviour:
Reset (RESET_N low at a rising edge):
- Outputs: DQM = all ones, DQ_OE = 0, DQOUT = 0 (OUT_REG=1), RDATA = 0, RVALID = 0, ERR = 0.
- The read pipeline is cleared. In-flight reads are discarded; no RVALID follows reset release.
- With OUT_REG=0, DQ_OE is forced 0 while RESET_N is low.

Write path:
- OUT_REG=1: WR_EN=1 in cycle n gives DQOUT = DATAIN(n) and DQ_OE = 1 in cycle n+1.
- OUT_REG=1 with WR_EN=0: DQ_OE = 0 next cycle and DQOUT holds its last value.
- OUT_REG=0: DQOUT = DATAIN and DQ_OE = WR_EN in the same cycle.

DQM, registered in all modes:
- In cycle n+1, DQM = DM(n) if WR_EN or RD_EN was asserted in cycle n.
- Otherwise DQM = all ones, which keeps idle beats masked.

Read pipeline:
- Implemented as a shift register rd_pipe, CAS_LAT+1 bits; RD_EN enters at bit 0.
- RD_EN in cycle n: the SDRAM drives data in cycle n+CAS_LAT, and DQIN is sampled at the end of that cycle.
- RDATA is updated and RVALID = 1 in cycle n+CAS_LAT+1.
- RDATA holds its value when RVALID=0.
- Back-to-back RD_EN produces back-to-back RVALID with no bubbles; throughput is 1 beat/clock.

Conflict handling:
- WR_EN and RD_EN both asserted: the write is executed, the read is dropped (does not enter rd_pipe), and ERR is set.
- WR_EN asserted while any rd_pipe bit that is still pending bus data is set: the write proceeds and ERR is set.
- ERR stays 1 until reset; no other input clears it.

Parameter checks: illegal CAS_LAT or a DSIZE that is not a multiple of 8 must be caught at elaboration (generate-time error).

Test Plan:
1. Reset: hold RESET_N=0 for 3 clocks with WR_EN=1 -> DQM=2'b11, DQ_OE=0, RVALID=0, ERR=0 throughout; release -> first write appears one cycle after the next WR_EN.
2. Write latency: OUT_REG=1, WR_EN pulse with DATAIN=16'hA5C3, DM=2'b01 at cycle 10 -> cycle 11: DQOUT=16'hA5C3, DQ_OE=1, DQM=2'b01; cycle 12: DQ_OE=0, DQM=2'b11.
3. Read alignment: CAS_LAT=2, RD_EN at cycles 20..23, DQIN=16'h1000+cycle -> RVALID=1 in cycles 23..26 with RDATA 16'h1016..16'h1019 in order.
4. CAS_LAT=3: single RD_EN at cycle 5, DQIN=16'hBEEF only in cycle 8 -> RVALID in cycle 9 only, RDATA=16'hBEEF.
5. Conflict: RD_EN at cycle 30, WR_EN at cycle 31 (CAS_LAT=2) -> ERR=1 from cycle 32 and stays 1; simultaneous WR_EN/RD_EN -> no RVALID for that beat.
6. Reset mid-read: RD_EN at cycle 40, RESET_N=0 in cycle 41 only -> no RVALID in cycles 42..45; DSIZE=32 run repeats scenarios 2–3 with 4-bit DQM.
